// File: rtl/ysyx_23060025_axi_sram.sv
// rtl/ysyx_23060025_axi_sram.sv - AXI4-Lite SRAM subordinate with independent read/write FSMs
module ysyx_23060025_axi_sram #(
  parameter int                  DATA_LEN   = 32,
  parameter int                  ADDR_LEN   = 32,
  parameter logic [ADDR_LEN-1:0] BASE_ADDR  = 32'h0f00_0000,
  parameter int                  DEPTH_LOG2 = 10,
  parameter int                  LATENCY    = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_LEN-1:0] addr_r_addr_i,
  input  logic                addr_r_valid_i,
  output logic                addr_r_ready_o,
  input  logic [2:0]          addr_r_size_i,
  output logic [DATA_LEN-1:0] r_data_o,
  output logic [1:0]          r_resp_o,
  output logic                r_valid_o,
  input  logic                r_ready_i,
  input  logic [ADDR_LEN-1:0] addr_w_addr_i,
  input  logic                addr_w_valid_i,
  output logic                addr_w_ready_o,
  input  logic [2:0]          addr_w_size_i,
  input  logic [DATA_LEN-1:0] w_data_i,
  input  logic [3:0]          w_strb_i,
  input  logic                w_valid_i,
  output logic                w_ready_o,
  output logic [1:0]          bkwd_resp_o,
  output logic                bkwd_valid_o,
  input  logic                bkwd_ready_i
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [ADDR_LEN:0]   WIN_LO   = {1'b0, BASE_ADDR};
  localparam logic [ADDR_LEN:0]   WIN_HI   = WIN_LO + (ADDR_LEN+1)'(4 * DEPTH);
  localparam logic [3:0]          LAT_LOAD = 4'(LATENCY - 1);
  localparam logic [1:0]          RESP_OK  = 2'b00;
  localparam logic [1:0]          RESP_ERR = 2'b10;

  localparam logic [1:0] R_IDLE    = 2'd0;
  localparam logic [1:0] R_LAT     = 2'd1;
  localparam logic [1:0] R_RESP    = 2'd2;

  localparam logic [2:0] W_IDLE    = 3'd0;
  localparam logic [2:0] W_ADDR_OK = 3'd1;
  localparam logic [2:0] W_DATA_OK = 3'd2;
  localparam logic [2:0] W_LAT     = 3'd3;
  localparam logic [2:0] W_RESP    = 3'd4;

  // Window check done one bit wider so a window ending at the top of the address space cannot wrap.
  function automatic logic addr_hit(input logic [ADDR_LEN-1:0] a);
    return ({1'b0, a} >= WIN_LO) && ({1'b0, a} < WIN_HI);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] addr_idx(input logic [ADDR_LEN-1:0] a);
    return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
  endfunction

  logic [DATA_LEN-1:0]   mem [DEPTH];

  logic [1:0]            r_state, r_next;
  logic [3:0]            r_cnt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_err;
  logic                  ar_hs;
  logic [DATA_LEN-1:0]   rd_word;

  logic [2:0]            w_state, w_next;
  logic [3:0]            w_cnt;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_err;
  logic [DATA_LEN-1:0]   w_data_q;
  logic [3:0]            w_strb_q;
  logic                  aw_hs, w_hs, w_commit;

  assign ar_hs    = addr_r_valid_i && addr_r_ready_o;
  assign aw_hs    = addr_w_valid_i && addr_w_ready_o;
  assign w_hs     = w_valid_i && w_ready_o;
  assign w_commit = (w_state == W_LAT) && (w_cnt == 4'd0) && !w_err;

  // Read port with write-first bypass: a commit landing on the same edge is visible to the sample.
  always_comb begin
    rd_word = mem[r_idx];
    if (w_commit && (w_idx == r_idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb_q[b]) rd_word[b*8 +: 8] = w_data_q[b*8 +: 8];
      end
    end
  end

  // Read channel next-state.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_LAT;
      R_LAT:   if (r_cnt == 4'd0) r_next = R_RESP;
      R_RESP:  if (r_ready_i) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read channel registers; ready is a registered decode so it reads 0 while in reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= R_IDLE;
      r_cnt          <= 4'd0;
      r_idx          <= '0;
      r_err          <= 1'b0;
      r_data_o       <= '0;
      r_resp_o       <= RESP_OK;
      r_valid_o      <= 1'b0;
      addr_r_ready_o <= 1'b0;
    end else begin
      r_state        <= r_next;
      addr_r_ready_o <= (r_next == R_IDLE);
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_idx <= addr_idx(addr_r_addr_i);
            r_err <= !addr_hit(addr_r_addr_i) || (addr_r_size_i > 3'd2);
            r_cnt <= LAT_LOAD;
          end
        end
        R_LAT: begin
          if (r_cnt == 4'd0) begin
            r_valid_o <= 1'b1;
            r_resp_o  <= r_err ? RESP_ERR : RESP_OK;
            r_data_o  <= r_err ? '0 : rd_word;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        R_RESP: begin
          if (r_ready_i) r_valid_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Write channel next-state; AW and W may complete together or in either order.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_next = W_LAT;
        else if (aw_hs)    w_next = W_ADDR_OK;
        else if (w_hs)     w_next = W_DATA_OK;
      end
      W_ADDR_OK: if (w_hs) w_next = W_LAT;
      W_DATA_OK: if (aw_hs) w_next = W_LAT;
      W_LAT:     if (w_cnt == 4'd0) w_next = W_RESP;
      W_RESP:    if (bkwd_ready_i) w_next = W_IDLE;
      default:   w_next = W_IDLE;
    endcase
  end

  // Write channel registers; address and data halves are captured on their own handshakes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state        <= W_IDLE;
      w_cnt          <= 4'd0;
      w_idx          <= '0;
      w_err          <= 1'b0;
      w_data_q       <= '0;
      w_strb_q       <= 4'd0;
      bkwd_valid_o   <= 1'b0;
      bkwd_resp_o    <= RESP_OK;
      addr_w_ready_o <= 1'b0;
      w_ready_o      <= 1'b0;
    end else begin
      w_state        <= w_next;
      addr_w_ready_o <= (w_next == W_IDLE) || (w_next == W_DATA_OK);
      w_ready_o      <= (w_next == W_IDLE) || (w_next == W_ADDR_OK);
      if (aw_hs) begin
        w_idx <= addr_idx(addr_w_addr_i);
        w_err <= !addr_hit(addr_w_addr_i) || (addr_w_size_i > 3'd2);
      end
      if (w_hs) begin
        w_data_q <= w_data_i;
        w_strb_q <= w_strb_i;
      end
      if ((w_next == W_LAT) && (w_state != W_LAT)) begin
        w_cnt <= LAT_LOAD;
      end else if ((w_state == W_LAT) && (w_cnt != 4'd0)) begin
        w_cnt <= w_cnt - 4'd1;
      end
      if ((w_state == W_LAT) && (w_cnt == 4'd0)) begin
        bkwd_valid_o <= 1'b1;
        bkwd_resp_o  <= w_err ? RESP_ERR : RESP_OK;
      end else if ((w_state == W_RESP) && bkwd_ready_i) begin
        bkwd_valid_o <= 1'b0;
      end
    end
  end

  // Storage array: byte-strobed commit on the terminal latency cycle; contents survive reset.
  always_ff @(posedge clock) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb_q[b]) mem[w_idx][b*8 +: 8] <= w_data_q[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_axi_sram.sv
// tb/tb_ysyx_23060025_axi_sram.sv - self-checking bench for the AXI4-Lite SRAM subordinate
module tb_ysyx_23060025_axi_sram;

  localparam logic [31:0] BASE       = 32'h0f00_0000;
  localparam int          DEPTH_LOG2 = 10;
  localparam int          LAT        = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr_r_addr_i = '0;
  logic        addr_r_valid_i = 1'b0;
  logic        addr_r_ready_o;
  logic [2:0]  addr_r_size_i = '0;
  logic [31:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_valid_o;
  logic        r_ready_i = 1'b0;
  logic [31:0] addr_w_addr_i = '0;
  logic        addr_w_valid_i = 1'b0;
  logic        addr_w_ready_o;
  logic [2:0]  addr_w_size_i = '0;
  logic [31:0] w_data_i = '0;
  logic [3:0]  w_strb_i = '0;
  logic        w_valid_i = 1'b0;
  logic        w_ready_o;
  logic [1:0]  bkwd_resp_o;
  logic        bkwd_valid_o;
  logic        bkwd_ready_i = 1'b0;

  ysyx_23060025_axi_sram #(
    .DATA_LEN(32), .ADDR_LEN(32), .BASE_ADDR(BASE), .DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LAT)
  ) dut (
    .clock(clock), .reset(reset),
    .addr_r_addr_i(addr_r_addr_i), .addr_r_valid_i(addr_r_valid_i), .addr_r_ready_o(addr_r_ready_o),
    .addr_r_size_i(addr_r_size_i), .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o),
    .r_ready_i(r_ready_i),
    .addr_w_addr_i(addr_w_addr_i), .addr_w_valid_i(addr_w_valid_i), .addr_w_ready_o(addr_w_ready_o),
    .addr_w_size_i(addr_w_size_i), .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i),
    .w_ready_o(w_ready_o), .bkwd_resp_o(bkwd_resp_o), .bkwd_valid_o(bkwd_valid_o),
    .bkwd_ready_i(bkwd_ready_i)
  );

  always #5 clock = ~clock;

  int chk  = 0;
  int errs = 0;

  logic [31:0] mdl [int];

  typedef struct {
    logic [31:0] waddr; logic [2:0] wsize; logic [31:0] wdata; logic [3:0] wstrb; int wmode;
    logic [1:0]  exp_wresp;
    logic [31:0] raddr; logic [2:0] rsize; int rhold;
    logic [31:0] exp_rdata; logic [1:0] exp_rresp;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit mdl_ok(input logic [31:0] a, input logic [2:0] size);
    longint la, lb;
    la = longint'(a);
    lb = longint'(BASE);
    return (la >= lb) && (la < lb + 4 * (longint'(1) << DEPTH_LOG2)) && (size <= 3'd2);
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [2:0] size, input logic [31:0] d,
                           input logic [3:0] strb, output logic [1:0] resp);
    int i;
    logic [31:0] word;
    if (!mdl_ok(a, size)) begin
      resp = 2'b10;
    end else begin
      i = int'((a - BASE) / 4);
      word = mdl.exists(i) ? mdl[i] : 32'h0;
      for (int b = 0; b < 4; b++) if (strb[b]) word[b*8 +: 8] = d[b*8 +: 8];
      mdl[i] = word;
      resp = 2'b00;
    end
  endtask

  task automatic mdl_read(input logic [31:0] a, input logic [2:0] size,
                          output logic [31:0] d, output logic [1:0] resp);
    int i;
    if (!mdl_ok(a, size)) begin
      d = 32'h0; resp = 2'b10;
    end else begin
      i = int'((a - BASE) / 4);
      d = mdl.exists(i) ? mdl[i] : 32'h0;
      resp = 2'b00;
    end
  endtask

  // mode 0: AW and W together; 1: W first, AW 3 cycles later; 2: AW first, W 3 cycles later.
  task automatic do_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data,
                          input logic [3:0] strb, input int mode,
                          output logic [1:0] resp, output int lat);
    int t, last;
    bit aw_done, w_done, hs_aw, hs_w;
    t = 0; last = 0; aw_done = 0; w_done = 0; lat = -1; resp = 2'b11;
    addr_w_addr_i = addr; addr_w_size_i = size; w_data_i = data; w_strb_i = strb;
    addr_w_valid_i = (mode != 1);
    w_valid_i      = (mode != 2);
    while (t < 60) begin
      if (mode == 1 && w_done && !aw_done) begin
        check("split_wfirst_readies", {62'd0, w_ready_o, addr_w_ready_o}, 64'b01);
        if (t >= last + 3) addr_w_valid_i = 1'b1;
      end
      if (mode == 2 && aw_done && !w_done) begin
        check("split_awfirst_readies", {62'd0, w_ready_o, addr_w_ready_o}, 64'b10);
        if (t >= last + 3) w_valid_i = 1'b1;
      end
      hs_aw = addr_w_valid_i && addr_w_ready_o;
      hs_w  = w_valid_i && w_ready_o;
      @(posedge clock);
      t++;
      @(negedge clock);
      if (hs_aw) begin aw_done = 1; last = t; addr_w_valid_i = 1'b0; end
      if (hs_w)  begin w_done  = 1; last = t; w_valid_i      = 1'b0; end
      if (bkwd_valid_o) begin
        lat  = t - last;
        resp = bkwd_resp_o;
        break;
      end
    end
    addr_w_valid_i = 1'b0;
    w_valid_i      = 1'b0;
    if (lat >= 0) begin
      bkwd_ready_i = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bkwd_ready_i = 1'b0;
      check("bvalid_drop", {63'd0, bkwd_valid_o}, 64'd0);
      check("aw_ready_after_b", {62'd0, addr_w_ready_o, w_ready_o}, 64'b11);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] size, input int hold,
                         output logic [31:0] data, output logic [1:0] resp, output int lat);
    int t, last;
    bit hs;
    t = 0; last = 0; lat = -1; data = 32'h0; resp = 2'b11;
    addr_r_addr_i = addr; addr_r_size_i = size; addr_r_valid_i = 1'b1;
    while (t < 60) begin
      hs = addr_r_valid_i && addr_r_ready_o;
      @(posedge clock);
      t++;
      @(negedge clock);
      if (hs) begin last = t; addr_r_valid_i = 1'b0; end
      if (r_valid_o) begin
        lat  = t - last;
        data = r_data_o;
        resp = r_resp_o;
        break;
      end
    end
    addr_r_valid_i = 1'b0;
    if (lat >= 0) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clock);
        @(negedge clock);
        check("r_hold_stable", {29'd0, r_valid_o, r_data_o, r_resp_o}, {29'd0, 1'b1, data, resp});
      end
      r_ready_i = 1'b1;
      @(posedge clock);
      @(negedge clock);
      r_ready_i = 1'b0;
      check("rvalid_drop", {63'd0, r_valid_o}, 64'd0);
      check("ar_ready_after_r", {63'd0, addr_r_ready_o}, 64'd1);
    end
  endtask

  initial begin
    logic [1:0]  wresp, rresp, eresp, dresp;
    logic [31:0] rdata, edata;
    int          wlat, rlat;

    tbl[0]  = '{32'h0f000000, 3'd2, 32'h00c0ffee, 4'hf, 0, 2'b00, 32'h0f000000, 3'd2, 0, 32'h00c0ffee, 2'b00};
    tbl[1]  = '{32'h0f000010, 3'd2, 32'hdeadbeef, 4'hf, 0, 2'b00, 32'h0f000010, 3'd2, 5, 32'hdeadbeef, 2'b00};
    tbl[2]  = '{32'h0f000020, 3'd2, 32'h11223344, 4'hf, 0, 2'b00, 32'h0f000020, 3'd2, 0, 32'h11223344, 2'b00};
    tbl[3]  = '{32'h0f000021, 3'd0, 32'h0000ab00, 4'h2, 0, 2'b00, 32'h0f000020, 3'd2, 0, 32'h1122ab44, 2'b00};
    tbl[4]  = '{32'h80000000, 3'd2, 32'hcafef00d, 4'hf, 0, 2'b10, 32'h80000000, 3'd2, 1, 32'h00000000, 2'b10};
    tbl[5]  = '{32'h0f000ffc, 3'd2, 32'h0badf00d, 4'hf, 0, 2'b00, 32'h0f000ffc, 3'd2, 0, 32'h0badf00d, 2'b00};
    tbl[6]  = '{32'h0f001000, 3'd2, 32'hffffffff, 4'hf, 0, 2'b10, 32'h0f001000, 3'd2, 0, 32'h00000000, 2'b10};
    tbl[7]  = '{32'h0effffff, 3'd0, 32'hffffffff, 4'hf, 0, 2'b10, 32'h0f000ffc, 3'd2, 0, 32'h0badf00d, 2'b00};
    tbl[8]  = '{32'h0f000010, 3'd3, 32'h12345678, 4'hf, 0, 2'b10, 32'h0f000010, 3'd2, 0, 32'hdeadbeef, 2'b00};
    tbl[9]  = '{32'h0f000030, 3'd2, 32'ha5a5a5a5, 4'hf, 1, 2'b00, 32'h0f000030, 3'd2, 0, 32'ha5a5a5a5, 2'b00};
    tbl[10] = '{32'h0f000034, 3'd2, 32'h5a5a5a5a, 4'hf, 2, 2'b00, 32'h0f000034, 3'd2, 0, 32'h5a5a5a5a, 2'b00};
    tbl[11] = '{32'h0f000032, 3'd1, 32'h12340000, 4'hc, 0, 2'b00, 32'h0f000030, 3'd2, 0, 32'h1234a5a5, 2'b00};
    tbl[12] = '{32'h0f000044, 3'd2, 32'h77777777, 4'hf, 1, 2'b00, 32'h0f000000, 3'd2, 0, 32'h00c0ffee, 2'b00};
    tbl[13] = '{32'h0f000048, 3'd2, 32'h88888888, 4'hf, 2, 2'b00, 32'h0f000020, 3'd3, 2, 32'h00000000, 2'b10};
    tbl[14] = '{32'h0f000004, 3'd2, 32'h01010101, 4'h0, 0, 2'b00, 32'h0effffc0, 3'd2, 0, 32'h00000000, 2'b10};

    // Reset state while held, then readies after release.
    @(negedge clock);
    check("reset_outputs",
          {24'd0, addr_r_ready_o, addr_w_ready_o, w_ready_o, r_valid_o, bkwd_valid_o, r_resp_o, bkwd_resp_o, r_data_o},
          64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("ready_after_reset", {61'd0, addr_r_ready_o, addr_w_ready_o, w_ready_o}, 64'b111);

    // Directed table: write then read back.
    for (int i = 0; i < 15; i++) begin
      do_write(tbl[i].waddr, tbl[i].wsize, tbl[i].wdata, tbl[i].wstrb, tbl[i].wmode, wresp, wlat);
      mdl_write(tbl[i].waddr, tbl[i].wsize, tbl[i].wdata, tbl[i].wstrb, dresp);
      check($sformatf("tbl%0d_wresp", i), {62'd0, wresp}, {62'd0, tbl[i].exp_wresp});
      check($sformatf("tbl%0d_wlat", i), 64'(wlat), 64'(LAT));
      do_read(tbl[i].raddr, tbl[i].rsize, tbl[i].rhold, rdata, rresp, rlat);
      check($sformatf("tbl%0d_rdata", i), {32'd0, rdata}, {32'd0, tbl[i].exp_rdata});
      check($sformatf("tbl%0d_rresp", i), {62'd0, rresp}, {62'd0, tbl[i].exp_rresp});
      check($sformatf("tbl%0d_rlat", i), 64'(rlat), 64'(LAT));
    end

    // Same-edge write commit and read sample on index 4: read sees the merged new word.
    fork
      begin
        logic [1:0] fr; int fl;
        do_write(32'h0f000010, 3'd2, 32'h5555aaaa, 4'b0101, 0, fr, fl);
        check("bypass_wlat", 64'(fl), 64'(LAT));
      end
      begin
        logic [31:0] fd; logic [1:0] fr; int fl;
        do_read(32'h0f000010, 3'd2, 0, fd, fr, fl);
        check("bypass_rlat", 64'(fl), 64'(LAT));
        check("bypass_rdata", {32'd0, fd}, {32'd0, 32'hde55beaa});
      end
    join
    mdl_write(32'h0f000010, 3'd2, 32'h5555aaaa, 4'b0101, dresp);
    do_read(32'h0f000010, 3'd2, 0, rdata, rresp, rlat);
    check("bypass_persist", {32'd0, rdata}, {32'd0, 32'hde55beaa});

    // Reset during W_LAT while a read response is pending.
    addr_r_addr_i = 32'h0f000020; addr_r_size_i = 3'd2; addr_r_valid_i = 1'b1;
    @(posedge clock); @(negedge clock);
    addr_r_valid_i = 1'b0;
    @(posedge clock); @(negedge clock);
    addr_w_addr_i = 32'h0f000020; addr_w_size_i = 3'd2; w_data_i = 32'hffffffff; w_strb_i = 4'hf;
    addr_w_valid_i = 1'b1; w_valid_i = 1'b1;
    @(posedge clock); @(negedge clock);
    addr_w_valid_i = 1'b0; w_valid_i = 1'b0;
    check("rst_pre_rvalid", {63'd0, r_valid_o}, 64'd1);
    reset = 1'b1;
    #1;
    check("rst_async_outputs",
          {26'd0, r_valid_o, bkwd_valid_o, addr_r_ready_o, addr_w_ready_o, w_ready_o, r_data_o, r_resp_o},
          64'd0);
    @(posedge clock); @(posedge clock); @(negedge clock);
    reset = 1'b0;
    @(posedge clock); @(negedge clock);
    do_read(32'h0f000020, 3'd2, 0, rdata, rresp, rlat);
    check("rst_old_data", {32'd0, rdata}, {32'd0, 32'h1122ab44});
    check("rst_read_lat", 64'(rlat), 64'(LAT));

    // Randomized traffic against the reference model.
    for (int k = 0; k < 16; k++) begin
      logic [31:0] d;
      d = $urandom;
      do_write(BASE + 32'd400 + 32'(4 * k), 3'd2, d, 4'hf, 0, wresp, wlat);
      mdl_write(BASE + 32'd400 + 32'(4 * k), 3'd2, d, 4'hf, eresp);
      check("rnd_prewrite_resp", {62'd0, wresp}, {62'd0, eresp});
    end
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a, d;
      logic [2:0]  sz;
      logic [3:0]  st;
      if ($urandom_range(0, 9) == 0)
        a = ($urandom_range(0, 1) == 0) ? 32'h0f001000 + 32'(4 * $urandom_range(0, 15))
                                        : 32'h0effff00 + 32'(4 * $urandom_range(0, 15));
      else
        a = BASE + 32'd400 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 0) begin
        d  = $urandom;
        st = 4'($urandom_range(0, 15));
        do_write(a, sz, d, st, int'($urandom_range(0, 2)), wresp, wlat);
        mdl_write(a, sz, d, st, eresp);
        check("rnd_wresp", {62'd0, wresp}, {62'd0, eresp});
        check("rnd_wlat", 64'(wlat), 64'(LAT));
      end else begin
        do_read(a, sz, int'($urandom_range(0, 2)), rdata, rresp, rlat);
        mdl_read(a, sz, edata, eresp);
        check("rnd_rdata", {32'd0, rdata}, {32'd0, edata});
        check("rnd_rresp", {62'd0, rresp}, {62'd0, eresp});
        check("rnd_rlat", 64'(rlat), 64'(LAT));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", chk, errs);
    $finish;
  end

endmodule
